// File: rtl/sh4a_mac_ctrl.sv
// SH-4A multiply/MAC sequencer: accepts execute-stage requests, forms operands for the
// two-stage multiply-add datapath, saturates its result and owns MACH/MACL.
module sh4a_mac_ctrl #(
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic        req_sat,
    output logic [31:0] mac_mul_src1,
    output logic [31:0] mac_mul_src2,
    output logic [63:0] mac_add_src1,
    output logic [63:0] mac_add_src2,
    input  logic [63:0] mac_result,
    output logic [31:0] mach,
    output logic [31:0] macl,
    output logic        busy,
    output logic        done
);

    // The ISSUE/WAIT sequence is built around a two-cycle datapath.
    if (LATENCY != 2) begin : g_latency_check
        $error("sh4a_mac_ctrl supports LATENCY == 2 only");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP      = 4'd0,
        OP_MUL_L    = 4'd1,
        OP_MULS_W   = 4'd2,
        OP_MULU_W   = 4'd3,
        OP_DMULS_L  = 4'd4,
        OP_DMULU_L  = 4'd5,
        OP_MAC_L    = 4'd6,
        OP_MAC_W    = 4'd7,
        OP_CLRMAC   = 4'd8,
        OP_LDS_MACH = 4'd9,
        OP_LDS_MACL = 4'd10
    } op_t;

    state_t      state_q, state_d;
    op_t         op_q, op_d;
    logic        sat_q, sat_d;
    logic [31:0] mach_q, mach_d;
    logic [31:0] macl_q, macl_d;
    logic [31:0] mul_src1_q, mul_src1_d;
    logic [31:0] mul_src2_q, mul_src2_d;
    logic [63:0] add_src1_q, add_src1_d;
    logic [63:0] add_src2_q, add_src2_d;
    logic        done_q, done_d;

    op_t         op_in;
    logic        is_word_op;
    logic        is_signed_op;
    logic        word_sext;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] cross_sum;
    logic [63:0] corr_term;
    logic [63:0] acc_term;
    logic [63:0] mac_acc;

    // Operand formation from the request and the current accumulator.
    always_comb begin
        op_in        = op_t'(req_op);
        is_word_op   = (op_in == OP_MULS_W) || (op_in == OP_MULU_W) || (op_in == OP_MAC_W);
        word_sext    = (op_in != OP_MULU_W);
        is_signed_op = (op_in == OP_MUL_L) || (op_in == OP_MULS_W) || (op_in == OP_DMULS_L) ||
                       (op_in == OP_MAC_L) || (op_in == OP_MAC_W);
        opa = is_word_op ? {{16{word_sext & req_rs1[15]}}, req_rs1[15:0]} : req_rs1;
        opb = is_word_op ? {{16{word_sext & req_rs2[15]}}, req_rs2[15:0]} : req_rs2;

        // Turns the unsigned 32x32 product into the two's-complement product mod 2^64.
        cross_sum = (opa[31] ? opb : '0) + (opb[31] ? opa : '0);
        corr_term = is_signed_op ? (64'd0 - {cross_sum, 32'd0}) : '0;

        mac_acc = {mach_q, macl_q};
        case (op_in)
            OP_MAC_L: acc_term = req_sat ? {{16{mach_q[15]}}, mach_q[15:0], macl_q} : mac_acc;
            OP_MAC_W: acc_term = req_sat ? {{32{macl_q[31]}}, macl_q} : mac_acc;
            default:  acc_term = '0;
        endcase
    end

    logic [63:0] res;
    logic        macl_pos_ovf;
    logic        macl_neg_ovf;
    logic        macw_pos_ovf;
    logic        macw_neg_ovf;

    always_comb begin
        res          = mac_result;
        macl_pos_ovf = $signed(res) > $signed(64'h0000_7FFF_FFFF_FFFF);
        macl_neg_ovf = $signed(res) < $signed(64'hFFFF_8000_0000_0000);
        macw_pos_ovf = $signed(res) > $signed(64'h0000_0000_7FFF_FFFF);
        macw_neg_ovf = $signed(res) < $signed(64'hFFFF_FFFF_8000_0000);
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        sat_d      = sat_q;
        mach_d     = mach_q;
        macl_d     = macl_q;
        mul_src1_d = mul_src1_q;
        mul_src2_d = mul_src2_q;
        add_src1_d = add_src1_q;
        add_src2_d = add_src2_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    case (op_in)
                        OP_MUL_L, OP_MULS_W, OP_MULU_W, OP_DMULS_L,
                        OP_DMULU_L, OP_MAC_L, OP_MAC_W: begin
                            state_d    = ST_ISSUE;
                            op_d       = op_in;
                            sat_d      = req_sat;
                            mul_src1_d = opa;
                            mul_src2_d = opb;
                            add_src1_d = acc_term;
                            add_src2_d = corr_term;
                        end
                        OP_CLRMAC: begin
                            mach_d = '0;
                            macl_d = '0;
                            done_d = 1'b1;
                        end
                        OP_LDS_MACH: begin
                            mach_d = req_rs1;
                            done_d = 1'b1;
                        end
                        OP_LDS_MACL: begin
                            macl_d = req_rs1;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end

            ST_ISSUE: state_d = ST_WAIT;

            ST_WAIT: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                case (op_q)
                    OP_MUL_L, OP_MULS_W, OP_MULU_W: macl_d = res[31:0];
                    OP_MAC_L: begin
                        if (sat_q && macl_pos_ovf) begin
                            {mach_d, macl_d} = 64'h0000_7FFF_FFFF_FFFF;
                        end else if (sat_q && macl_neg_ovf) begin
                            {mach_d, macl_d} = 64'hFFFF_8000_0000_0000;
                        end else begin
                            {mach_d, macl_d} = res;
                        end
                    end
                    OP_MAC_W: begin
                        // Saturating MAC.W flags overflow in MACH[0] and leaves the rest of MACH alone.
                        if (!sat_q) begin
                            {mach_d, macl_d} = res;
                        end else if (macw_pos_ovf) begin
                            macl_d    = 32'h7FFF_FFFF;
                            mach_d[0] = 1'b1;
                        end else if (macw_neg_ovf) begin
                            macl_d    = 32'h8000_0000;
                            mach_d[0] = 1'b1;
                        end else begin
                            macl_d = res[31:0];
                        end
                    end
                    default: {mach_d, macl_d} = res;
                endcase
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_NOP;
            sat_q      <= 1'b0;
            mach_q     <= '0;
            macl_q     <= '0;
            mul_src1_q <= '0;
            mul_src2_q <= '0;
            add_src1_q <= '0;
            add_src2_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            sat_q      <= sat_d;
            mach_q     <= mach_d;
            macl_q     <= macl_d;
            mul_src1_q <= mul_src1_d;
            mul_src2_q <= mul_src2_d;
            add_src1_q <= add_src1_d;
            add_src2_q <= add_src2_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        req_ready    = (state_q == ST_IDLE);
        busy         = (state_q != ST_IDLE);
        done         = done_q;
        mach         = mach_q;
        macl         = macl_q;
        mac_mul_src1 = mul_src1_q;
        mac_mul_src2 = mul_src2_q;
        mac_add_src1 = add_src1_q;
        mac_add_src2 = add_src2_q;
    end

endmodule

// File: tb/tb_sh4a_mac_ctrl.sv
// Self-checking bench for sh4a_mac_ctrl: a registered datapath stand-in plus an
// arithmetic reference model of MACH/MACL driven by directed and random requests.
module tb_sh4a_mac_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic        req_sat;
    logic [31:0] mac_mul_src1;
    logic [31:0] mac_mul_src2;
    logic [63:0] mac_add_src1;
    logic [63:0] mac_add_src2;
    logic [63:0] mac_result;
    logic [31:0] mach;
    logic [31:0] macl;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_mach = '0;
    logic [31:0] exp_macl = '0;

    always #5 clk = ~clk;

    sh4a_mac_ctrl #(.LATENCY(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_rs1      (req_rs1),
        .req_rs2      (req_rs2),
        .req_sat      (req_sat),
        .mac_mul_src1 (mac_mul_src1),
        .mac_mul_src2 (mac_mul_src2),
        .mac_add_src1 (mac_add_src1),
        .mac_add_src2 (mac_add_src2),
        .mac_result   (mac_result),
        .mach         (mach),
        .macl         (macl),
        .busy         (busy),
        .done         (done)
    );

    // Datapath stand-in: result of the operands is visible two edges after they are driven.
    logic [63:0] dp_q = '0;
    always @(posedge clk) begin
        dp_q <= ({32'd0, mac_mul_src1} * {32'd0, mac_mul_src2}) + mac_add_src1 + mac_add_src2;
    end
    assign mac_result = dp_q;

    // Reference model: returns the expected done latency (0 = no done pulse).
    function automatic int model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic s);
        logic [31:0] aw, bw;
        logic [63:0] ps, pu, acc, sum;
        longint      sv;
        if (op == 4'd3) begin
            aw = {16'd0, a[15:0]};
            bw = {16'd0, b[15:0]};
        end else if (op == 4'd2 || op == 4'd7) begin
            aw = {{16{a[15]}}, a[15:0]};
            bw = {{16{b[15]}}, b[15:0]};
        end else begin
            aw = a;
            bw = b;
        end
        ps = 64'(longint'($signed(aw)) * longint'($signed(bw)));
        pu = {32'd0, aw} * {32'd0, bw};
        case (op)
            4'd1, 4'd2: begin exp_macl = ps[31:0]; return 3; end
            4'd3: begin exp_macl = pu[31:0]; return 3; end
            4'd4: begin {exp_mach, exp_macl} = ps; return 3; end
            4'd5: begin {exp_mach, exp_macl} = pu; return 3; end
            4'd6: begin
                acc = {exp_mach, exp_macl};
                if (s) acc = 64'(longint'($signed(acc[47:0])));
                sum = acc + ps;
                sv  = longint'(sum);
                if (s && sv > 64'sd140737488355327) sum = 64'h0000_7FFF_FFFF_FFFF;
                else if (s && sv < -64'sd140737488355328) sum = 64'hFFFF_8000_0000_0000;
                {exp_mach, exp_macl} = sum;
                return 3;
            end
            4'd7: begin
                if (!s) begin
                    {exp_mach, exp_macl} = {exp_mach, exp_macl} + ps;
                end else begin
                    sv = longint'($signed(exp_macl)) + longint'(ps);
                    if (sv > 64'sd2147483647) begin
                        exp_macl = 32'h7FFF_FFFF;
                        exp_mach[0] = 1'b1;
                    end else if (sv < -64'sd2147483648) begin
                        exp_macl = 32'h8000_0000;
                        exp_mach[0] = 1'b1;
                    end else begin
                        exp_macl = sv[31:0];
                    end
                end
                return 3;
            end
            4'd8: begin exp_mach = '0; exp_macl = '0; return 1; end
            4'd9: begin exp_mach = a; return 1; end
            4'd10: begin exp_macl = a; return 1; end
            default: return 0;
        endcase
    endfunction

    // Presents one request, waits for acceptance, then watches done for five cycles.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic s, output bit acc_ok, output int first, output int cnt);
        acc_ok = 1'b0;
        first  = 0;
        cnt    = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_rs1   = a;
        req_rs2   = b;
        req_sat   = s;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin
                acc_ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 4'd0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (first == 0) first = c;
                cnt++;
            end
        end
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = '0;
        req_rs1   = '0;
        req_rs2   = '0;
        req_sat   = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_checks++; if (mach !== 32'd0) begin n_fail++; $display("FAIL reset_mach: got %h want 0", mach); end
        n_checks++; if (macl !== 32'd0) begin n_fail++; $display("FAIL reset_macl: got %h want 0", macl); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        n_checks++;
        if ({mac_mul_src1, mac_mul_src2, mac_add_src1, mac_add_src2} !== '0) begin
            n_fail++;
            $display("FAIL reset_mac_outs: got %h %h %h %h want all 0", mac_mul_src1, mac_mul_src2,
                     mac_add_src1, mac_add_src2);
        end
        exp_mach = '0;
        exp_macl = '0;
    endtask

    task automatic test_mac_l_basic;
        bit ok; int first, cnt;
        run_op(4'd6, 32'hFFFF_FFFF, 32'd2, 1'b0, ok, first, cnt);
        void'(model(4'd6, 32'hFFFF_FFFF, 32'd2, 1'b0));
        n_checks++; if (!ok) begin n_fail++; $display("FAIL macl_basic_accept: got 0 want 1"); end
        n_checks++; if (first != 3 || cnt != 1) begin n_fail++; $display("FAIL macl_basic_done: got latency %0d count %0d want 3 1", first, cnt); end
        n_checks++; if (mach !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL macl_basic_mach: got %h want ffffffff", mach); end
        n_checks++; if (macl !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL macl_basic_macl: got %h want fffffffe", macl); end
    endtask

    task automatic test_dmul;
        bit ok; int first, cnt;
        run_op(4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, ok, first, cnt);
        void'(model(4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0));
        n_checks++; if ({mach, macl} !== 64'hFFFF_FFFE_0000_0001) begin n_fail++; $display("FAIL dmulu: got %h_%h want fffffffe_00000001", mach, macl); end
        run_op(4'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, ok, first, cnt);
        void'(model(4'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0));
        n_checks++; if ({mach, macl} !== 64'h0000_0000_0000_0001) begin n_fail++; $display("FAIL dmuls: got %h_%h want 00000000_00000001", mach, macl); end
        n_checks++; if (first != 3 || cnt != 1) begin n_fail++; $display("FAIL dmuls_done: got latency %0d count %0d want 3 1", first, cnt); end
    endtask

    task automatic test_mac_w_sat;
        bit ok; int first, cnt;
        run_op(4'd10, 32'h7FFF_FFF0, 32'd0, 1'b0, ok, first, cnt);
        void'(model(4'd10, 32'h7FFF_FFF0, 32'd0, 1'b0));
        n_checks++; if (macl !== 32'h7FFF_FFF0 || first != 1 || cnt != 1) begin n_fail++; $display("FAIL lds_macl: got %h latency %0d count %0d want 7ffffff0 1 1", macl, first, cnt); end
        run_op(4'd9, 32'd0, 32'd0, 1'b0, ok, first, cnt);
        void'(model(4'd9, 32'd0, 32'd0, 1'b0));
        n_checks++; if (mach !== 32'd0 || first != 1) begin n_fail++; $display("FAIL lds_mach: got %h latency %0d want 0 1", mach, first); end
        run_op(4'd7, 32'h10, 32'h10, 1'b1, ok, first, cnt);
        void'(model(4'd7, 32'h10, 32'h10, 1'b1));
        n_checks++; if (macl !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL macw_sat_macl: got %h want 7fffffff", macl); end
        n_checks++; if (mach !== 32'h0000_0001) begin n_fail++; $display("FAIL macw_sat_mach: got %h want 00000001", mach); end
    endtask

    task automatic test_mac_l_sat;
        bit ok; int first, cnt;
        run_op(4'd9, 32'h0000_7FFF, 32'd0, 1'b0, ok, first, cnt);
        run_op(4'd10, 32'hFFFF_FFF0, 32'd0, 1'b0, ok, first, cnt);
        run_op(4'd6, 32'h10, 32'h1, 1'b1, ok, first, cnt);
        n_checks++; if ({mach, macl} !== 64'h0000_7FFF_FFFF_FFFF) begin n_fail++; $display("FAIL macl_sat_pos: got %h_%h want 00007fff_ffffffff", mach, macl); end
        run_op(4'd9, 32'hFFFF_8000, 32'd0, 1'b0, ok, first, cnt);
        run_op(4'd10, 32'h0000_0010, 32'd0, 1'b0, ok, first, cnt);
        run_op(4'd6, 32'hFFFF_FFE0, 32'h1, 1'b1, ok, first, cnt);
        n_checks++; if ({mach, macl} !== 64'hFFFF_8000_0000_0000) begin n_fail++; $display("FAIL macl_sat_neg: got %h_%h want ffff8000_00000000", mach, macl); end
        exp_mach = 32'hFFFF_8000;
        exp_macl = 32'h0000_0000;
        run_op(4'd0, 32'h1234, 32'h5678, 1'b0, ok, first, cnt);
        n_checks++; if (!ok || cnt != 0 || {mach, macl} !== {exp_mach, exp_macl}) begin n_fail++; $display("FAIL nop: got accept %0d done count %0d regs %h_%h want 1 0 unchanged", ok, cnt, mach, macl); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a_v[3], b_v[3], want[3];
        int acc_cyc[3];
        int k = 0, nd = 0, low = 0;
        logic rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_v[i] = $urandom;
            b_v[i] = $urandom;
            void'(model(4'd1, a_v[i], b_v[i], 1'b0));
            want[i] = exp_macl;
        end
        for (int t = 0; t < 16; t++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (nd < 3) begin
                    n_checks++;
                    if (macl !== want[nd]) begin n_fail++; $display("FAIL b2b_macl_%0d: got %h want %h", nd, macl, want[nd]); end
                end
                nd++;
            end
            if (k < 3) begin
                req_valid = 1'b1;
                req_op    = 4'd1;
                req_rs1   = a_v[k];
                req_rs2   = b_v[k];
                req_sat   = 1'b0;
                rdy       = req_ready;
                if (!rdy) low++;
            end else begin
                req_valid = 1'b0;
            end
            @(posedge clk);
            if (k < 3 && rdy) begin
                acc_cyc[k] = t;
                k++;
            end
        end
        req_valid = 1'b0;
        n_checks++; if (k != 3) begin n_fail++; $display("FAIL b2b_accepts: got %0d want 3", k); end
        n_checks++;
        if (k == 3 && (acc_cyc[1] - acc_cyc[0] != 3 || acc_cyc[2] - acc_cyc[1] != 3)) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d %0d %0d want spacing 3", acc_cyc[0], acc_cyc[1], acc_cyc[2]);
        end
        n_checks++; if (low != 4) begin n_fail++; $display("FAIL b2b_ready_low: got %0d want 4", low); end
        n_checks++; if (nd != 3) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 3", nd); end
        n_checks++; if (mach !== exp_mach) begin n_fail++; $display("FAIL b2b_mach: got %h want %h", mach, exp_mach); end
    endtask

    task automatic test_reset_in_wait;
        bit ok; int first, cnt;
        run_op(4'd9, 32'h1234_5678, 32'd0, 1'b0, ok, first, cnt);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 4'd5;
        req_rs1   = 32'hDEAD_BEEF;
        req_rs2   = 32'hCAFE_F00D;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b1 || req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_wait_busy: got busy %b ready %b want 1 0", busy, req_ready); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_checks++; if ({mach, macl} !== 64'd0) begin n_fail++; $display("FAIL rst_wait_regs: got %h_%h want 0", mach, macl); end
        n_checks++; if (done !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_wait_state: got done %b busy %b ready %b want 0 0 1", done, busy, req_ready); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0 || {mach, macl} !== 64'd0) begin n_fail++; $display("FAIL rst_wait_late: got done %b regs %h_%h want 0 0", done, mach, macl); end
        exp_mach = '0;
        exp_macl = '0;
        run_op(4'd8, 32'd0, 32'd0, 1'b0, ok, first, cnt);
        n_checks++; if (!ok || first != 1 || cnt != 1) begin n_fail++; $display("FAIL rst_clrmac_done: got accept %0d latency %0d count %0d want 1 1 1", ok, first, cnt); end
    endtask

    task automatic test_random;
        bit ok; int first, cnt, lat;
        logic [3:0] op;
        logic [31:0] a, b;
        logic s;
        for (int i = 0; i < 80; i++) begin
            op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? -32'($urandom_range(0, 255)) : $urandom;
            s  = 1'($urandom_range(0, 1));
            lat = model(op, a, b, s);
            run_op(op, a, b, s, ok, first, cnt);
            n_checks++;
            if (!ok || first != lat || cnt != (lat != 0 ? 1 : 0)) begin
                n_fail++;
                $display("FAIL rand_done[%0d] op %0d: got accept %0d latency %0d count %0d want latency %0d", i, op, ok, first, cnt, lat);
            end
            n_checks++;
            if (mach !== exp_mach || macl !== exp_macl) begin
                n_fail++;
                $display("FAIL rand_regs[%0d] op %0d s %0d a %h b %h: got %h_%h want %h_%h", i, op, s, a, b, mach, macl, exp_mach, exp_macl);
                exp_mach = mach;
                exp_macl = macl;
            end
        end
    endtask

    initial begin
        test_reset();
        test_mac_l_basic();
        test_dmul();
        test_mac_w_sat();
        test_mac_l_sat();
        test_back_to_back();
        test_reset_in_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
